// File: rtl/pcihellocore_led_pkg.sv
//==== pcihellocore_led_pkg -- register map, CTRL layout and mode encodings ====
//==== Rev 1.0 ====
`default_nettype none

package pcihellocore_led_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_PAT_A  = 3'd2;
  localparam logic [2:0] ADDR_PAT_B  = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_COUNT  = 3'd6;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_MODE_LSB   = 1;
  localparam int CTRL_MODE_MSB   = 2;
  localparam int CTRL_IRQ_EN_BIT = 3;
  localparam int CTRL_W          = 4;

  localparam int STATUS_WRAP_BIT   = 0;
  localparam int STATUS_ACTIVE_BIT = 1;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROTL   = 2'd2,
    MODE_ROTR   = 2'd3
  } led_mode_e;

  // Field order mirrors the CTRL bit layout so a 4-bit cast maps directly.
  typedef struct packed {
    logic      irq_en;
    led_mode_e mode;
    logic      en;
  } led_ctrl_t;

  function automatic logic ctrl_active(input led_ctrl_t c);
    return c.en && (c.mode != MODE_MANUAL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcihellocore_led_sequencer_if.sv
//==== pcihellocore_led_sequencer_if -- Avalon-MM slave bus for the LED sequencer ====
//==== Rev 1.0 ====
`default_nettype none

interface pcihellocore_led_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

`default_nettype wire

// File: rtl/pcihellocore_led_prescaler.sv
//==== pcihellocore_led_prescaler -- programmable tick generator, PERIOD=0 acts as 1 ====
//==== Rev 1.0 ====
`default_nettype none

module pcihellocore_led_prescaler #(
  parameter int CNT_W = 24
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             enable,
  input  wire logic             restart,
  input  wire logic [CNT_W-1:0] period,
  output logic                  tick,
  output logic      [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] last_val;

  always_comb begin
    last_val = (period == '0) ? '0 : (period - CNT_W'(1));
    // A restart in the same cycle swallows the tick.
    tick     = enable && !restart && (count_q == last_val);
    count_d  = count_q + CNT_W'(1);
    if (restart || !enable || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pcihellocore_led_sequencer.sv
//==== pcihellocore_led_sequencer -- Avalon-MM LED controller with blink/rotate sequencing ====
//==== Rev 1.0 ====
`default_nettype none

module pcihellocore_led_sequencer
  import pcihellocore_led_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 24
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  pcihellocore_led_sequencer_if.slave bus,
  output logic        [WIDTH-1:0] out_port,
  output logic                    irq
);

  localparam int              STEP_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIDTH - 1);

  logic [WIDTH-1:0]  data_q,   data_d;
  led_ctrl_t         ctrl_q,   ctrl_d;
  logic [WIDTH-1:0]  pat_a_q,  pat_a_d;
  logic [WIDTH-1:0]  pat_b_q,  pat_b_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              wrap_q,   wrap_d;
  logic              irq_q,    irq_d;
  logic              phase_q,  phase_d;
  logic [STEP_W-1:0] step_q,   step_d;
  logic [WIDTH-1:0]  rot_q,    rot_d;
  logic [WIDTH-1:0]  out_q,    out_d;

  logic             wr_en;
  logic             wr_data, wr_ctrl, wr_pat_a, wr_pat_b, wr_period, wr_status;
  logic             active;
  logic             restart;
  logic             tick;
  logic             wrap_set;
  logic             wrap_clr;
  logic [CNT_W-1:0] count;
  logic [31:0]      rdata;

  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
    return (v << 1) | (v >> (WIDTH - 1));
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
    return (v >> 1) | (v << (WIDTH - 1));
  endfunction

  always_comb begin
    wr_en     = bus.chipselect && !bus.write_n;
    wr_data   = wr_en && (bus.address == ADDR_DATA);
    wr_ctrl   = wr_en && (bus.address == ADDR_CTRL);
    wr_pat_a  = wr_en && (bus.address == ADDR_PAT_A);
    wr_pat_b  = wr_en && (bus.address == ADDR_PAT_B);
    wr_period = wr_en && (bus.address == ADDR_PERIOD);
    wr_status = wr_en && (bus.address == ADDR_STATUS);

    data_d   = wr_data   ? bus.writedata[WIDTH-1:0]  : data_q;
    ctrl_d   = wr_ctrl   ? led_ctrl_t'(bus.writedata[CTRL_W-1:0]) : ctrl_q;
    pat_a_d  = wr_pat_a  ? bus.writedata[WIDTH-1:0]  : pat_a_q;
    pat_b_d  = wr_pat_b  ? bus.writedata[WIDTH-1:0]  : pat_b_q;
    period_d = wr_period ? bus.writedata[CNT_W-1:0]  : period_q;

    active   = ctrl_active(ctrl_q);
    restart  = wr_ctrl || wr_period || (wr_pat_a && active);
    wrap_clr = wr_status && bus.writedata[STATUS_WRAP_BIT];
  end

  pcihellocore_led_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (active),
    .restart (restart),
    .period  (period_q),
    .tick    (tick),
    .count   (count)
  );

  // Pattern engine; tick is only ever high while active, so mode is meaningful.
  always_comb begin
    phase_d  = phase_q;
    step_d   = step_q;
    rot_d    = rot_q;
    wrap_set = 1'b0;
    if (restart) begin
      phase_d = 1'b0;
      step_d  = '0;
      rot_d   = pat_a_d;
    end else if (tick) begin
      case (ctrl_q.mode)
        MODE_BLINK: begin
          phase_d  = !phase_q;
          wrap_set = phase_q;
        end
        MODE_ROTL, MODE_ROTR: begin
          rot_d = (ctrl_q.mode == MODE_ROTL) ? rot_left(rot_q) : rot_right(rot_q);
          if (step_q == STEP_LAST) begin
            step_d   = '0;
            wrap_set = 1'b1;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
        default: begin
          phase_d = phase_q;
        end
      endcase
    end

    wrap_d = wrap_set || (wrap_q && !wrap_clr);
    irq_d  = wrap_q && ctrl_q.irq_en;
  end

  // The pin reflects post-update state so writes and ticks reach it one cycle later.
  always_comb begin
    out_d = data_d;
    if (ctrl_d.en) begin
      case (ctrl_d.mode)
        MODE_BLINK:           out_d = phase_d ? pat_b_d : pat_a_d;
        MODE_ROTL, MODE_ROTR: out_d = rot_d;
        default:              out_d = data_d;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA:   rdata[WIDTH-1:0]  = data_q;
      ADDR_CTRL:   rdata[CTRL_W-1:0] = ctrl_q;
      ADDR_PAT_A:  rdata[WIDTH-1:0]  = pat_a_q;
      ADDR_PAT_B:  rdata[WIDTH-1:0]  = pat_b_q;
      ADDR_PERIOD: rdata[CNT_W-1:0]  = period_q;
      ADDR_STATUS: begin
        rdata[STATUS_WRAP_BIT]   = wrap_q;
        rdata[STATUS_ACTIVE_BIT] = active;
      end
      ADDR_COUNT:  rdata[CNT_W-1:0]  = count;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      ctrl_q   <= '0;
      pat_a_q  <= '0;
      pat_b_q  <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      irq_q    <= 1'b0;
      phase_q  <= 1'b0;
      step_q   <= '0;
      rot_q    <= '0;
      out_q    <= '0;
    end else begin
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      pat_a_q  <= pat_a_d;
      pat_b_q  <= pat_b_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      irq_q    <= irq_d;
      phase_q  <= phase_d;
      step_q   <= step_d;
      rot_q    <= rot_d;
      out_q    <= out_d;
    end
  end

  assign bus.readdata = rdata;
  assign out_port     = out_q;
  assign irq          = irq_q;

endmodule

`default_nettype wire
